// File: rtl/ook_pkt_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ook_pkt_receiver
// Description : On-off-keyed packet receiver; captures one bit per window into
//               a shift buffer and flags/exports frames matching a sync pattern.
// Revision    : 1.0  initial release
// ============================================================================
module ook_pkt_receiver #(
  parameter int                 BIT_CYCLES = 10000,
  parameter int                 FRAME_W    = 64,
  parameter logic [FRAME_W-1:0] SYNC_MASK  = FRAME_W'(64'h7C00_001F_0000_01FF),
  parameter logic [FRAME_W-1:0] SYNC_VALUE = FRAME_W'(64'h7C00_001F_0000_01FF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  output logic               pkt_rec,
  output logic [FRAME_W-1:0] spi_data
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic               din_m;
  logic               din_s;
  logic               q;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] shift_buf;
  logic [FRAME_W-1:0] shift_next;
  logic               sample;
  logic               bit_in;
  logic               match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
    end else begin
      din_m <= din;
      din_s <= din_m;
    end
  end

  assign sample = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (sample) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A pulse arriving on the sample cycle itself still belongs to this bit.
  assign bit_in     = q | din_s;
  assign shift_next = {shift_buf[FRAME_W-2:0], bit_in};
  assign match      = ((shift_next & SYNC_MASK) == SYNC_VALUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (sample) begin
      q <= 1'b0;
    end else if (din_s) begin
      q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_buf <= '0;
      pkt_rec   <= 1'b0;
      spi_data  <= '0;
    end else if (sample) begin
      shift_buf <= shift_next;
      pkt_rec   <= match;
      if (match) begin
        spi_data <= shift_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ook_pkt_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ook_pkt_receiver
// Description : Directed self-checking bench for ook_pkt_receiver.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ook_pkt_receiver;

  localparam logic [63:0] FRAME = 64'hFD12_345F_A5C3_A3FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        pkt_rec;
  logic [63:0] spi_data;
  logic        rst2;
  logic        din2;
  logic        pkt_rec2;
  logic [63:0] spi_data2;

  int checks   = 0;
  int failures = 0;

  always #50 clk = ~clk;

  ook_pkt_receiver #(.BIT_CYCLES(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .pkt_rec  (pkt_rec),
    .spi_data (spi_data)
  );

  ook_pkt_receiver dut2 (
    .clk      (clk),
    .rst      (rst2),
    .din      (din2),
    .pkt_rec  (pkt_rec2),
    .spi_data (spi_data2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on the negedge just before a window's first edge; consumes one window.
  task automatic send_win(input logic b, input int off);
    repeat (off) @(negedge clk);
    din = b;
    @(negedge clk);
    din = 1'b0;
    repeat (7 - off) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] frame_v;
    logic        any_rec;
    longint      t0, t1, t2;
    int          budget;

    frame_v = FRAME;
    rst  = 1'b1;
    din  = 1'b0;
    rst2 = 1'b1;
    din2 = 1'b1;

    // Reset held while din toggles
    repeat (10) begin
      @(negedge clk);
      din = ~din;
    end
    din = 1'b0;
    @(negedge clk);
    check("rst_pkt_rec", pkt_rec, 0);
    check("rst_spi_data", spi_data, 0);
    check("rst_shift_buf", dut.shift_buf, 0);
    check("rst_cnt", dut.cnt, 0);
    rst = 1'b0;

    // Single pulse then empty window, then two pulses in one window
    send_win(1'b1, 0);
    send_win(1'b0, 0);
    check("bit_capture_10", dut.shift_buf, 64'h2);
    din = 1'b1; @(negedge clk); din = 1'b0;
    repeat (2) @(negedge clk);
    din = 1'b1; @(negedge clk); din = 1'b0;
    repeat (4) @(negedge clk);
    check("two_pulses_one_bit", dut.shift_buf, 64'h5);

    // Pulse reaching the latch exactly on the sample cycle
    send_win(1'b1, 5);
    check("pulse_on_sample", dut.shift_buf, 64'hB);
    check("latch_cleared", dut.q, 0);
    send_win(1'b0, 0);
    check("after_sample_pulse", dut.shift_buf, 64'h16);
    check("no_sync_pkt_rec_early", pkt_rec, 0);

    // 64 bits with no sync runs
    do_reset();
    any_rec = 1'b0;
    for (int i = 0; i < 64; i++) begin
      send_win((i == 0) || (i == 2), 0);
      any_rec = any_rec | pkt_rec;
    end
    check("no_sync_pkt_rec", any_rec, 0);
    check("no_sync_spi_data", spi_data, 0);
    check("no_sync_shift_buf", dut.shift_buf, 64'hA000_0000_0000_0000);

    // Full valid frame
    do_reset();
    for (int i = 0; i < 64; i++) begin
      send_win(frame_v[63 - i], 0);
      if (i == 39) check("frame_bit40_pkt_rec", pkt_rec, 0);
      if (i == 62) check("frame_bit63_pkt_rec", pkt_rec, 0);
    end
    check("frame_pkt_rec", pkt_rec, 1);
    check("frame_spi_data", spi_data, FRAME);
    repeat (3) @(negedge clk);
    check("frame_pkt_rec_hold", pkt_rec, 1);
    check("frame_spi_data_hold", spi_data, FRAME);
    repeat (5) @(negedge clk);
    send_win(1'b0, 0);
    check("sync_lost_pkt_rec", pkt_rec, 0);
    check("sync_lost_spi_held", spi_data, FRAME);

    // Reset in the middle of a frame and of a window
    do_reset();
    for (int i = 0; i < 40; i++) send_win(1'b1, 0);
    din = 1'b1; @(negedge clk); din = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pkt_rec", pkt_rec, 0);
    check("midrst_spi_data", spi_data, 0);
    check("midrst_shift_buf", dut.shift_buf, 0);
    check("midrst_latch", dut.q, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      send_win(frame_v[63 - i], 0);
      if (i == 62) check("refill_bit63_pkt_rec", pkt_rec, 0);
    end
    check("refill_pkt_rec", pkt_rec, 1);
    check("refill_spi_data", spi_data, FRAME);

    // Default 10000-cycle window at 10 MHz: 1 ms per bit
    rst2 = 1'b0;
    t0 = $time;
    t1 = 0;
    t2 = 0;
    budget = 0;
    while (dut2.shift_buf[0] !== 1'b1 && budget < 25000) begin
      @(negedge clk);
      budget++;
    end
    t1 = $time;
    check("slow_first_bit_time", 64'(t1 - t0), 64'd1_000_000);
    budget = 0;
    while (dut2.shift_buf[1] !== 1'b1 && budget < 25000) begin
      @(negedge clk);
      budget++;
    end
    t2 = $time;
    check("slow_bit_period", 64'(t2 - t1), 64'd1_000_000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
